// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed MUL / DIV / REM unit for the EX stage.
// Uses the ALU's ALUControl encoding: 4'b0010 MUL, 4'b0110 DIV, 4'b1010 REM.
// The result follows RISC-V M semantics. MUL uses shift-add on magnitudes and
// DIV/REM use restoring division. The result sign is fixed after iteration.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, divide-by-zero,
// the most-negative / -1 overflow, and MUL by zero skip the iteration.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             DivByZero,
    output logic             Illegal
);

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_REM = 4'b1010;

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Request captured at accept
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Working registers.
    // MUL: work_a is the shifting multiplicand, work_b the shifting multiplier,
    //      and acc the product.
    // DIV/REM: work_a is the dividend that turns into the quotient, work_b the
    //          divisor, and acc the partial remainder.
    logic [WIDTH-1:0] work_a;
    logic [WIDTH-1:0] work_b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             neg_res;
    logic             dz_q;

    logic             is_mul, is_div, is_rem, is_divrem, is_legal;
    logic             prep_dz, prep_ovf, prep_mzero, early_out;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] special_result;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] fix_mag, fix_result;

    assign is_mul    = (op_q == OP_MUL);
    assign is_div    = (op_q == OP_DIV);
    assign is_rem    = (op_q == OP_REM);
    assign is_divrem = is_div | is_rem;
    assign is_legal  = is_mul | is_divrem;

    assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
    assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;

    assign prep_dz    = is_divrem && (b_q == '0);
    assign prep_ovf   = is_divrem && (a_q == MOST_NEG) && (b_q == '1);
    assign prep_mzero = is_mul && ((a_q == '0) || (b_q == '0));

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = prep_dz | prep_ovf | prep_mzero;
`else
    assign early_out = 1'b0;
`endif

    // One restoring-division step: shift in the next dividend bit and try to subtract
    assign rem_sh   = {acc, work_a[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, work_b};

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    // Closed-form results for the special cases that can skip iteration
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        special_result = '0;
        if (prep_dz) begin
            special_result = is_div ? '1 : a_q;
        end else if (prep_ovf) begin
            special_result = is_div ? a_q : '0;
        end
    end

    // Final sign correction, then the divide-by-zero override
    always_comb begin
        fix_mag    = is_div ? work_a : acc;
        fix_result = neg_res ? -fix_mag : fix_mag;
        if (dz_q) begin
            fix_result = is_div ? '1 : a_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start) state_next = S_PREP;
            S_PREP: state_next = (!is_legal || early_out) ? S_DONE : S_CALC;
            S_CALC: if (cnt == LAST_CNT) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments to avoid simulation races.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: capture the request, iterate, and write the result and flags
    always_ff @(posedge clk) begin
        // NOTE: only the visible outputs are reset; the working registers are always loaded before use.
        if (rst) begin
            Result    <= '0;
            DivByZero <= 1'b0;
            Illegal   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= ALUControl;
                        a_q       <= A;
                        b_q       <= B;
                        DivByZero <= 1'b0;
                        Illegal   <= 1'b0;
                    end
                end
                S_PREP: begin
                    work_a  <= a_mag;
                    work_b  <= b_mag;
                    acc     <= '0;
                    cnt     <= '0;
                    neg_res <= is_rem ? a_q[WIDTH-1] : (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    dz_q    <= prep_dz;
                    if (!is_legal) begin
                        Result  <= '0;
                        Illegal <= 1'b1;
                    end else if (early_out) begin
                        Result    <= special_result;
                        DivByZero <= prep_dz;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_mul) begin
                        if (work_b[0]) acc <= acc + work_a;
                        work_a <= work_a << 1;
                        work_b <= work_b >> 1;
                    end else if (!rem_diff[WIDTH]) begin
                        acc    <= rem_diff[WIDTH-1:0];
                        work_a <= {work_a[WIDTH-2:0], 1'b1};
                    end else begin
                        acc    <= rem_sh[WIDTH-1:0];
                        work_a <= {work_a[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    Result    <= fix_result;
                    DivByZero <= dz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// The driver pushes the expected response when a request is accepted.
// The monitor pops and compares an entry whenever done is seen.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int LAT_FULL = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = W + 2;
`endif

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_REM = 4'b1010;
    localparam logic [3:0] OP_BAD = 4'b1100;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        logic         ill;
        int           acc_cyc;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   alu = 4'b0000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, done, dbz, ill;
    logic [W-1:0] result;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ALUControl (alu),
        .A          (a),
        .B          (b),
        .ready      (ready),
        .done       (done),
        .Result     (result),
        .DivByZero  (dbz),
        .Illegal    (ill)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request and hold it until it is accepted. Push the expected response only if a done is expected.
    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] er, input logic ed,
                         input logic ei, input int lat, input bit expect_done);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        start = 1'b1; alu = op; a = av; b = bv;
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            check({name, "_accept_timeout"}, 32'(ready), 32'd1);
        end else if (expect_done) begin
            e.res = er; e.dbz = ed; e.ill = ei;
            e.acc_cyc = cyc + 1; e.lat = lat; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || !ready) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            check("drain_queue", 32'(sb.size()), 32'd0);
            check("drain_ready", 32'(ready), 32'd1);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expected entry
    initial begin : monitor
        bit   after_done;
        exp_t e;
        after_done = 1'b0;
        forever begin
            @(negedge clk);
            if (after_done) begin
                check("ready_after_done", 32'(ready), 32'd1);
                check("done_one_cycle", 32'(done), 32'd0);
                after_done = 1'b0;
            end else if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_divbyzero"}, 32'(dbz), 32'(e.dbz));
                    check({e.name, "_illegal"}, 32'(ill), 32'(e.ill));
                    check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
                    check({e.name, "_ready_low"}, 32'(ready), 32'd0);
                    after_done = !rst;
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (50000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : driver
        int g;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_divbyzero", 32'(dbz), 32'd0);
        check("reset_illegal", 32'(ill), 32'd0);

        // MUL
        issue("mul_pos",   OP_MUL, 32'd150, 32'd50, 32'd7500, 1'b0, 1'b0, LAT_FULL, 1);
        issue("mul_negA",  OP_MUL, -32'sd150, 32'd50, 32'hFFFFE2B4, 1'b0, 1'b0, LAT_FULL, 1);
        issue("mul_negAB", OP_MUL, -32'sd150, -32'sd50, 32'd7500, 1'b0, 1'b0, LAT_FULL, 1);
        issue("mul_minx-1", OP_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, LAT_FULL, 1);
        issue("mul_zero",  OP_MUL, 32'd0, 32'd5, 32'd0, 1'b0, 1'b0, LAT_EARLY, 1);

        // DIV / REM
        issue("div_15_5",  OP_DIV, 32'd15, 32'd5, 32'd3, 1'b0, 1'b0, LAT_FULL, 1);
        issue("div_3_5",   OP_DIV, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, LAT_FULL, 1);
        issue("div_m17_7", OP_DIV, -32'sd17, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, LAT_FULL, 1);
        issue("rem_m17_7", OP_REM, -32'sd17, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, LAT_FULL, 1);
        issue("rem_15_5",  OP_REM, 32'd15, 32'd5, 32'd0, 1'b0, 1'b0, LAT_FULL, 1);
        issue("div_m8_m3", OP_DIV, -32'sd8, -32'sd3, 32'd2, 1'b0, 1'b0, LAT_FULL, 1);
        issue("rem_m8_m3", OP_REM, -32'sd8, -32'sd3, 32'hFFFFFFFE, 1'b0, 1'b0, LAT_FULL, 1);

        // Special cases
        issue("div_by0",   OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0, LAT_EARLY, 1);
        issue("rem_by0",   OP_REM, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, LAT_EARLY, 1);
        drain();
        repeat (3) @(negedge clk);
        check("divbyzero_held", 32'(dbz), 32'd1);
        check("rem_by0_result_held", result, 32'd5);
        issue("div_ovf",   OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, LAT_EARLY, 1);
        issue("rem_ovf",   OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, LAT_EARLY, 1);

        // Start while busy is ignored, including in the done cycle
        drain();
        issue("mul_busy",  OP_MUL, 32'd150, 32'd50, 32'd7500, 1'b0, 1'b0, LAT_FULL, 1);
        start = 1'b1; alu = OP_DIV; a = 32'd7; b = 32'd9;
        repeat (3) @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!done && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("busy_done_seen", 32'(done), 32'd1);
        start = 1'b1; alu = OP_DIV; a = 32'd99; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 6) @(negedge clk);
        check("busy_result_held", result, 32'd7500);
        check("busy_ready_idle", 32'(ready), 32'd1);

        // Reset in the middle of CALC
        issue("mul_rst",   OP_MUL, 32'd12, 32'd34, 32'd0, 1'b0, 1'b0, LAT_FULL, 0);
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        repeat (W + 6) @(negedge clk);
        issue("mul_after_rst", OP_MUL, 32'd150, 32'd50, 32'd7500, 1'b0, 1'b0, LAT_FULL, 1);

        // Illegal code, then a legal op that clears Illegal
        issue("illegal",   OP_BAD, 32'd150, 32'd50, 32'd0, 1'b0, 1'b1, 1, 1);
        drain();
        repeat (2) @(negedge clk);
        check("illegal_held", 32'(ill), 32'd1);
        issue("div_after_ill", OP_DIV, 32'd15, 32'd5, 32'd3, 1'b0, 1'b0, LAT_FULL, 1);

        drain();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
